// File: rtl/falafel_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : falafel_lock_ctrl (with package falafel_pkg)
//  Description : Hardware spinlock client for the falafel allocator. Acquires
//                or releases a shared lock word in memory through a
//                single-outstanding request/grant/response port.
//                Acquire = read word, if zero write own ID, read back to
//                verify ownership; failures retry after a backoff.
//  Ports       : clk_i, rst_ni (async, active-low)
//                acquire_i, release_i         request pulses (IDLE only)
//                lock_ptr_i, lock_id_i        lock address / owner ID
//                ack_o, err_o                 completion / rejection pulses
//                locked_o, busy_o             status
//                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                mem_gnt_i, mem_rvalid_i, mem_rdata_i   memory port
//  Options     : `FALAFEL_LOCK_BACKOFF_EN enables exponential backoff
//                (2, 4, 8 ... BACKOFF_MAX cycles); otherwise backoff is a
//                single cycle and no counter exists.
//  Revision    : 1.0 - initial release
// ============================================================================

package falafel_pkg;
    localparam int unsigned DATA_W = 32;
endpackage

module falafel_lock_ctrl
    import falafel_pkg::*;
#(
    parameter int unsigned BACKOFF_MAX = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              acquire_i,
    input  logic              release_i,
    input  logic [DATA_W-1:0] lock_ptr_i,
    input  logic [DATA_W-1:0] lock_id_i,
    output logic              ack_o,
    output logic              err_o,
    output logic              locked_o,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // Reject illegal backoff limits at elaboration time.
    if (BACKOFF_MAX < 2 || (BACKOFF_MAX & (BACKOFF_MAX - 1)) != 0) begin : g_param_check
        $error("BACKOFF_MAX must be a power of two and at least 2");
    end

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RD_REQ   = 4'd1,
        ST_RD_WAIT  = 4'd2,
        ST_WR_REQ   = 4'd3,
        ST_WR_WAIT  = 4'd4,
        ST_VFY_REQ  = 4'd5,
        ST_VFY_WAIT = 4'd6,
        ST_BACKOFF  = 4'd7,
        ST_REL_REQ  = 4'd8,
        ST_REL_WAIT = 4'd9,
        ST_DONE     = 4'd10
    } state_e;

`ifdef FALAFEL_LOCK_BACKOFF_EN
    // Counter must be able to hold BACKOFF_MAX itself.
    localparam int unsigned c_cnt_w = $clog2(BACKOFF_MAX) + 1;
    localparam logic [c_cnt_w-1:0] c_bo_init = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_bo_max  = c_cnt_w'(BACKOFF_MAX);

    logic [c_cnt_w-1:0] bo_cnt_q, bo_cnt_d;
    logic [c_cnt_w-1:0] bo_len_q, bo_len_d;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   id_q, id_d;
    logic                locked_q, locked_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        locked_d = locked_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef FALAFEL_LOCK_BACKOFF_EN
        bo_cnt_d = bo_cnt_q;
        bo_len_d = bo_len_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Snapshot config so later register writes cannot disturb
                // the operation in flight.
                if (acquire_i || release_i) begin
                    ptr_d = lock_ptr_i;
                    id_d  = lock_id_i;
                end
                // Release has priority only when there is something to release.
                if (release_i && locked_q) begin
                    state_d = ST_REL_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = lock_ptr_i;
                    wdata_d = '0;
                end else if (acquire_i) begin
                    if (locked_q) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                    end else if (lock_id_i == '0) begin
                        // ID 0 is the "free" marker and can never own the lock.
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = lock_ptr_i;
`ifdef FALAFEL_LOCK_BACKOFF_EN
                        bo_len_d = c_bo_init;
`endif
                    end
                end else if (release_i) begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                end
            end

            ST_RD_REQ: begin
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                if (mem_rvalid_i) begin
                    if (mem_rdata_i == '0) begin
                        state_d = ST_WR_REQ;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = id_q;
                    end else begin
                        state_d = ST_BACKOFF;
`ifdef FALAFEL_LOCK_BACKOFF_EN
                        bo_cnt_d = bo_len_q - 1'b1;
`endif
                    end
                end
            end

            ST_WR_REQ: begin
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = ST_VFY_REQ;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = ptr_q;
                end
            end

            ST_VFY_REQ: begin
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_VFY_WAIT;
                end
            end

            ST_VFY_WAIT: begin
                if (mem_rvalid_i) begin
                    // Another client may have overwritten our ID between our
                    // read and write; only a matching read-back confers ownership.
                    if (mem_rdata_i == id_q) begin
                        locked_d = 1'b1;
                        state_d  = ST_DONE;
                        ack_d    = 1'b1;
                    end else begin
                        state_d = ST_BACKOFF;
`ifdef FALAFEL_LOCK_BACKOFF_EN
                        bo_cnt_d = bo_len_q - 1'b1;
`endif
                    end
                end
            end

            ST_BACKOFF: begin
`ifdef FALAFEL_LOCK_BACKOFF_EN
                // Counter was loaded with N-1, so the state lasts N cycles.
                if (bo_cnt_q == '0) begin
                    state_d  = ST_RD_REQ;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = ptr_q;
                    bo_len_d = (bo_len_q >= (c_bo_max >> 1)) ? c_bo_max : (bo_len_q << 1);
                end else begin
                    bo_cnt_d = bo_cnt_q - 1'b1;
                end
`else
                state_d = ST_RD_REQ;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = ptr_q;
`endif
            end

            ST_REL_REQ: begin
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = ST_REL_WAIT;
                end
            end

            ST_REL_WAIT: begin
                if (mem_rvalid_i) begin
                    locked_d = 1'b0;
                    state_d  = ST_DONE;
                    ack_d    = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            locked_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifdef FALAFEL_LOCK_BACKOFF_EN
            bo_cnt_q <= '0;
            bo_len_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            locked_q <= locked_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifdef FALAFEL_LOCK_BACKOFF_EN
            bo_cnt_q <= bo_cnt_d;
            bo_len_q <= bo_len_d;
`endif
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign locked_o    = locked_q;
    assign busy_o      = busy_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_falafel_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_falafel_lock_ctrl
//  Description : Directed self-checking bench for falafel_lock_ctrl with a
//                behavioural memory (configurable grant stall, scripted read
//                data, optional dropped write response).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_falafel_lock_ctrl;
    import falafel_pkg::*;

`ifdef FALAFEL_LOCK_BACKOFF_EN
    localparam int c_lat_cont = 27;   // 1 + (2+2) + (2+4) + (2+8) + 6
    localparam int c_lat_race = 15;   // 1 + 6 + 2 + 6
`else
    localparam int c_lat_cont = 16;   // 1 + 3*(2+1) + 6
    localparam int c_lat_race = 14;   // 1 + 6 + 1 + 6
`endif

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              r_acq = 1'b0;
    logic              r_rel = 1'b0;
    logic [DATA_W-1:0] r_ptr = 32'h100;
    logic [DATA_W-1:0] r_id  = 32'h0;
    logic              m_gnt = 1'b0;
    logic              m_rvalid = 1'b0;
    logic [DATA_W-1:0] m_rdata = '0;
    logic              tb_rvalid = 1'b0;
    logic [DATA_W-1:0] tb_rdata = '0;

    wire               w_rvalid = m_rvalid | tb_rvalid;
    wire  [DATA_W-1:0] w_rdata  = tb_rvalid ? tb_rdata : m_rdata;

    logic              w_ack, w_err, w_locked, w_busy, w_req, w_we;
    logic [DATA_W-1:0] w_addr, w_wdata;

    falafel_lock_ctrl #(.BACKOFF_MAX(64)) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .acquire_i    (r_acq),
        .release_i    (r_rel),
        .lock_ptr_i   (r_ptr),
        .lock_id_i    (r_id),
        .ack_o        (w_ack),
        .err_o        (w_err),
        .locked_o     (w_locked),
        .busy_o       (w_busy),
        .mem_req_o    (w_req),
        .mem_we_o     (w_we),
        .mem_addr_o   (w_addr),
        .mem_wdata_o  (w_wdata),
        .mem_gnt_i    (m_gnt),
        .mem_rvalid_i (w_rvalid),
        .mem_rdata_i  (w_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    int          gnt_wait = 0;
    int          stall = 0;
    bit          drop_wr = 0;
    bit          pend = 0;
    bit          pend_drop = 0;
    logic [31:0] pend_data = '0;
    int          n_rd = 0, n_wr = 0, req_cycles = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic [31:0] snap_addr = '0, snap_wdata = '0;
    logic        snap_we = 1'b0;

    always @(negedge clk) begin
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        if (!rst_ni) begin
            pend  = 0;
            stall = 0;
        end else begin
            if (pend) begin
                m_rvalid = !pend_drop;
                m_rdata  = pend_data;
                pend     = 0;
            end
            if (w_req) begin
                req_cycles++;
                if (stall == 0) begin
                    snap_addr  = w_addr;
                    snap_we    = w_we;
                    snap_wdata = w_wdata;
                end else begin
                    check("stall_addr",  w_addr,  snap_addr);
                    check("stall_we",    32'(w_we), 32'(snap_we));
                    check("stall_wdata", w_wdata, snap_wdata);
                end
                if (stall < gnt_wait) begin
                    stall++;
                end else begin
                    m_gnt     = 1'b1;
                    stall     = 0;
                    pend      = 1;
                    pend_drop = 0;
                    if (w_we) begin
                        n_wr++;
                        last_waddr  = w_addr;
                        last_wdata  = w_wdata;
                        mem[w_addr] = w_wdata;
                        pend_data   = '0;
                        pend_drop   = drop_wr;
                    end else begin
                        n_rd++;
                        if (rd_q.size() > 0) pend_data = rd_q.pop_front();
                        else if (mem.exists(w_addr)) pend_data = mem[w_addr];
                        else pend_data = '0;
                    end
                end
            end
        end
    end

    // ---------------- operation driver ----------------
    logic ack_tail = 1'b0;

    task automatic run_op(input bit acq, input bit rel, input bit swap_cfg,
                          output int lat, output logic err_seen, output bit early);
        logic [31:0] sv_ptr, sv_id;
        sv_ptr   = r_ptr;
        sv_id    = r_id;
        lat      = -1;
        err_seen = 1'b0;
        early    = 0;
        @(negedge clk);
        r_acq = acq;
        r_rel = rel;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            r_acq = 1'b0;
            r_rel = 1'b0;
            if (swap_cfg && k == 1) begin
                r_ptr = 32'h200;
                r_id  = 32'h6;
            end
            if (w_ack === 1'b1) begin
                lat      = k;
                err_seen = w_err;
                break;
            end
            if (w_locked === 1'b1) early = 1;
        end
        r_ptr = sv_ptr;
        r_id  = sv_id;
        @(negedge clk);
        ack_tail = w_ack;
    endtask

    int   lat;
    logic err;
    bit   early;
    int   b_rd, b_wr, b_req;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_locked", 32'(w_locked), 32'h0);
        check("rst_busy",   32'(w_busy),   32'h0);
        check("rst_ack",    32'(w_ack),    32'h0);
        check("rst_err",    32'(w_err),    32'h0);
        check("rst_req",    32'(w_req),    32'h0);
        check("rst_we",     32'(w_we),     32'h0);
        check("rst_addr",   w_addr,        32'h0);
        check("rst_wdata",  w_wdata,       32'h0);
        rst_ni = 1'b1;

        // Acquire with ID 0 is rejected without traffic
        r_ptr = 32'h100;
        r_id  = 32'h0;
        b_req = req_cycles;
        run_op(1, 0, 0, lat, err, early);
        check("id0_lat",    lat, 32'd1);
        check("id0_err",    32'(err), 32'h1);
        check("id0_notraf", req_cycles - b_req, 32'h0);
        check("id0_locked", 32'(w_locked), 32'h0);

        // Release while unlocked: plain ack, no traffic
        r_id  = 32'h5;
        b_req = req_cycles;
        run_op(0, 1, 0, lat, err, early);
        check("relnop_lat",    lat, 32'd1);
        check("relnop_err",    32'(err), 32'h0);
        check("relnop_notraf", req_cycles - b_req, 32'h0);

        // Uncontended acquire; config changes mid-flight must not matter
        mem[32'h100] = 32'h0;
        b_rd = n_rd; b_wr = n_wr;
        run_op(1, 0, 1, lat, err, early);
        check("acq_lat",     lat, 32'd7);
        check("acq_err",     32'(err), 32'h0);
        check("acq_locked",  32'(w_locked), 32'h1);
        check("acq_reads",   n_rd - b_rd, 32'd2);
        check("acq_writes",  n_wr - b_wr, 32'd1);
        check("acq_waddr",   last_waddr, 32'h100);
        check("acq_wdata",   last_wdata, 32'h5);
        check("acq_ackpulse", 32'(ack_tail), 32'h0);
        check("acq_idle",    32'(w_busy), 32'h0);

        // Acquire while already locked: ack, no traffic
        b_req = req_cycles;
        run_op(1, 0, 0, lat, err, early);
        check("reacq_lat",    lat, 32'd1);
        check("reacq_err",    32'(err), 32'h0);
        check("reacq_notraf", req_cycles - b_req, 32'h0);
        check("reacq_locked", 32'(w_locked), 32'h1);

        // Acquire + release together while locked, grant stalled 4 cycles
        gnt_wait = 4;
        b_wr = n_wr; b_req = req_cycles;
        run_op(1, 1, 0, lat, err, early);
        gnt_wait = 0;
        check("both_lat",     lat, 32'd7);
        check("both_locked",  32'(w_locked), 32'h0);
        check("both_writes",  n_wr - b_wr, 32'd1);
        check("both_waddr",   last_waddr, 32'h100);
        check("both_wdata",   last_wdata, 32'h0);
        check("both_reqcyc",  req_cycles - b_req, 32'd5);

        // Contended: three nonzero reads before the word frees up
        mem[32'h100] = 32'h0;
        rd_q = '{32'h9, 32'h9, 32'h9};
        b_rd = n_rd; b_wr = n_wr;
        run_op(1, 0, 0, lat, err, early);
        check("cont_lat",    lat, 32'(c_lat_cont));
        check("cont_reads",  n_rd - b_rd, 32'd5);
        check("cont_writes", n_wr - b_wr, 32'd1);
        check("cont_locked", 32'(w_locked), 32'h1);
        run_op(0, 1, 0, lat, err, early);
        check("cont_rel_lat",    lat, 32'd3);
        check("cont_rel_locked", 32'(w_locked), 32'h0);

        // Verify race: read-back shows another owner, then retry succeeds
        rd_q = '{32'h0, 32'h7, 32'h0};
        b_rd = n_rd; b_wr = n_wr;
        run_op(1, 0, 0, lat, err, early);
        check("race_lat",    lat, 32'(c_lat_race));
        check("race_early",  32'(early), 32'h0);
        check("race_locked", 32'(w_locked), 32'h1);
        check("race_reads",  n_rd - b_rd, 32'd4);
        check("race_writes", n_wr - b_wr, 32'd2);

        // Asynchronous reset while locked clears ownership immediately
        b_wr = n_wr;
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("rstlk_locked", 32'(w_locked), 32'h0);
        check("rstlk_busy",   32'(w_busy),   32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("rstlk_nowrite", n_wr - b_wr, 32'h0);

        // Reset in WR_WAIT, then a stale response must be ignored
        mem[32'h100] = 32'h0;
        drop_wr = 1;
        b_wr = n_wr;
        @(negedge clk);
        r_acq = 1'b1;
        for (int k = 0; k < 20 && n_wr == b_wr; k++) begin
            @(negedge clk);
            r_acq = 1'b0;
        end
        r_acq = 1'b0;
        check("wrw_reached", n_wr - b_wr, 32'd1);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("wrw_busy",   32'(w_busy),   32'h0);
        check("wrw_req",    32'(w_req),    32'h0);
        check("wrw_addr",   w_addr,        32'h0);
        check("wrw_wdata",  w_wdata,       32'h0);
        check("wrw_ack",    32'(w_ack),    32'h0);
        @(negedge clk);
        rst_ni    = 1'b1;
        drop_wr   = 0;
        tb_rvalid = 1'b1;
        tb_rdata  = 32'h5;
        b_req = req_cycles;
        repeat (2) @(negedge clk);
        tb_rvalid = 1'b0;
        @(negedge clk);
        check("stale_busy",   32'(w_busy),   32'h0);
        check("stale_ack",    32'(w_ack),    32'h0);
        check("stale_locked", 32'(w_locked), 32'h0);
        check("stale_notraf", req_cycles - b_req, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
